// File: rtl/uart_rx_if.sv
// uart_rx_if: interface that bundles the serial line and the byte-side outputs of uart_rx.
//
//   rx        serial line, asynchronous to clk, idle high (driven by the line side)
//   data      last correctly received byte
//   valid     one-cycle strobe: data has just been updated
//   frame_err one-cycle strobe: stop bit sampled low
//   busy      high while a frame is in progress
//
// The master modport is taken by the receiver. The slave modport is taken by whatever
// drives the line and consumes bytes.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Frame format is 1 start bit, 8 data bits sent LSB first,
// 1 stop bit, and no parity. It is the receive counterpart of uart_tx and takes the
// same BAUD/F parameters.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   bus (master)   rx in; data, valid, frame_err and busy out (see uart_rx_if)
//
// FSM states:
//   state       | meaning
//   ------------+---------------------------------------------------------------
//   S_IDLE      | line idle, waiting for a falling edge on rx_s
//   S_START     | counting to mid start bit, then confirming the start bit (or rejecting a glitch)
//   S_DATA      | sampling 8 data bits at their centres, LSB first
//   S_STOP      | sampling the stop bit at its centre: valid or frame_err
//   S_WAIT_IDLE | stop bit was low (break or line fault); wait for the line to go high
module uart_rx #(
    parameter int BAUD = 115200,
    parameter int F    = 50000000
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);

    localparam int CPB = F / BAUD;
    localparam int CW  = (CPB > 4) ? $clog2(CPB) : 2;

    localparam logic [CW-1:0] CNT_BIT_END = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_MID     = CW'(CPB / 2 - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx: clocks per bit F/BAUD = %0d is below the minimum of 4", CPB);
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_i;
    logic [7:0]    shreg;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          frame_err_q;
    logic          busy_q;

    logic          rx_meta;
    logic          rx_s;

    // Two-flop synchroniser. Both flops reset to 1, the idle level, so the line looks
    // idle straight after reset and releasing reset cannot create a false start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM. The strobes default low each cycle, so any strobe lasts exactly one
    // cycle. busy is registered and updated on the same edge as every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_i       <= '0;
            shreg       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state  <= S_START;
                        busy_q <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Line went back high before mid start bit: treat it as a glitch.
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= S_DATA;
                            bit_i <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt          <= '0;
                        shreg[bit_i] <= rx_s;
                        if (bit_i == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_i <= bit_i + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_STOP: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Return to idle at mid stop bit so that a start bit directly
                            // following this stop bit is still caught.
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                            state   <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= S_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

    // Strobe invariants: valid and frame_err are mutually exclusive and never repeat
    // on back-to-back cycles.
    a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(valid_q && frame_err_q));
    a_valid_single: assert property (@(posedge clk) disable iff (!rst)
        valid_q |=> !valid_q);
    a_frame_err_single: assert property (@(posedge clk) disable iff (!rst)
        frame_err_q |=> !frame_err_q);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the FPGA serial link: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Deserialises the asynchronous `rx` line into bytes.
- Emits a one-cycle `valid` strobe per good frame and a one-cycle `frame_err` strobe per bad stop bit.
- Sits between the board RX pin and byte consumers. It is the receive counterpart of the existing uart_tx and uses the same BAUD/F parameterisation.

Parameters:
- BAUD, 115200, line bit rate in bits/s.
- F, 50000000, clk frequency in Hz.
- CPB (localparam), F/BAUD with integer truncation, clocks per bit. CPB=434 at defaults. CPB < 4 is a configuration error; flag it at elaboration.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  last correctly received byte.
- valid  output  1  one-cycle strobe: data has just been updated.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high while a frame is being received (any state except IDLE).

Behaviour:
- Reset (rst=0, asynchronous):
  - data=8'h00, valid=0, frame_err=0, busy=0.
  - State=IDLE, counters cleared.
  - Synchroniser flops set to 1 (idle line), so release cannot fake a start bit.
- Input conditioning: rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s only.
- Timing: baud counter cnt runs 0..CPB-1; it is reloaded to 0 on every state entry. Bit index bit_i runs 0..7.
- IDLE:
  - busy=0.
  - rx_s==0 -> START, cnt=0.
- START: wait until cnt==CPB/2-1 (integer division, mid start bit), then sample rx_s.
  - rx_s==1 -> glitch: return to IDLE, no strobe.
  - rx_s==0 -> DATA, bit_i=0, cnt=0.
- DATA: at each cnt==CPB-1, sample rx_s into shift register position bit_i (LSB first) and set cnt=0.
  - bit_i==7 -> STOP.
  - Otherwise bit_i++.
- STOP: at cnt==CPB-1, sample rx_s (centre of stop bit).
  - rx_s==1: data <= assembled byte, valid=1 for exactly one cycle, state -> IDLE.
  - rx_s==0: frame_err=1 for one cycle, data unchanged, state -> WAIT_IDLE.
- WAIT_IDLE (break/line-fault recovery): stay until rx_s==1, then -> IDLE. No strobes; busy=1.
- Latency:
  - valid rises CPB/2 + 9*CPB cycles after rx_s first reads 0.
  - This is 2 further cycles after the pin edge because of the synchroniser.
  - Bench tolerance ±2 cycles.
- Back-to-back frames:
  - The receiver returns to IDLE at mid stop bit, so a start bit immediately after the stop bit is caught.
  - No minimum idle gap is required.
- Overrun: there is no backpressure. A new good frame overwrites data. The consumer must take data on valid.
- valid and frame_err are never high in the same cycle. Neither can be high in consecutive cycles.
- Reset mid-frame: everything returns to reset values immediately. A partial byte never reaches data and no strobe is emitted.
- Clock drift tolerance: mid-bit sampling gives about ±4% combined baud mismatch. This is guaranteed only when CPB is exact to within 1%.

Test Plan (F=50e6, BAUD=115200, CPB=434; driver bit period 434 clk):
- Send 0x55 after reset -> exactly one valid pulse, data=0x55, frame_err never 1, busy high only during the frame, valid about 4123 clk after the falling edge.
- Back-to-back 0xA3, 0x0F, 0xFF, 0x00 with zero idle gap -> four valid pulses, data sequence A3, 0F, FF, 00, no frame_err.
- Drive rx low for 100 clk then high, idle 2000 clk -> no valid, no frame_err; busy briefly 1 then 0; data keeps its prior value.
- Send 0x3C with stop bit forced 0, keep rx low 3000 clk, release, then send 0x81:
  - One frame_err pulse and no valid for the bad frame; data still holds the previous byte.
  - busy stays 1 until rx returns high.
  - 0x81 is then received with valid.
- Assert rst=0 (asynchronous, mid-clock) during data bit 4 of 0x96, release, then send 0x69 -> outputs zero immediately; no strobe for 0x96; data=0x69 with one valid.
- Drive 115200*1.03 baud (bit period 421 clk) with 0xC3, then 115200*0.97 baud (447 clk) with 0x3C -> both received correctly with valid.
